// File: rtl/food_placer_pkg.sv
// Shared constants and FSM encoding for the food placement block.
// Origins follow the VGA timing: sync width plus back porch on each axis.
package food_placer_pkg;

    localparam int unsigned H_SYNC_CYC  = 96;
    localparam int unsigned H_SYNC_BACK = 48;
    localparam int unsigned V_SYNC_CYC  = 2;
    localparam int unsigned V_SYNC_BACK = 33;

    localparam int unsigned H_ORIGIN   = H_SYNC_CYC + H_SYNC_BACK;
    localparam int unsigned V_ORIGIN   = V_SYNC_CYC + V_SYNC_BACK;
    localparam int unsigned CELL_SHIFT = 3;
    localparam int unsigned GRID_W     = 80;
    localparam int unsigned GRID_H     = 60;
    localparam int unsigned MAX_RETRY  = 15;

    typedef enum logic [1:0] {
        StIdle,
        StSample,
        StScan,
        StCommit
    } state_t;

endpackage

// File: rtl/food_placer_cell_quantizer.sv
// Clamps one raw VGA-timing coordinate to the playfield and converts it to a cell index.
module food_placer_cell_quantizer #(
    parameter int unsigned CELL_SHIFT = 3,
    parameter int unsigned ORIGIN     = 144,
    parameter int unsigned NUM_CELLS  = 80,
    parameter int unsigned CELL_W     = 7
) (
    input  logic [9:0]        i_coord,
    output logic [CELL_W-1:0] o_cell
);

    localparam logic signed [10:0] ORIGIN_S  = 11'(ORIGIN);
    localparam logic signed [10:0] SPAN_S    = 11'(NUM_CELLS << CELL_SHIFT);
    localparam logic [CELL_W-1:0]  LAST_CELL = CELL_W'(NUM_CELLS - 1);

    logic signed [10:0] w_rel;

    assign w_rel = $signed({1'b0, i_coord}) - ORIGIN_S;

    // The generator overshoots the active area by a few pixels on every side.
    always_comb begin
        o_cell = '0;
        if (w_rel[10]) begin
            o_cell = '0;
        end else if (w_rel >= SPAN_S) begin
            o_cell = LAST_CELL;
        end else begin
            o_cell = CELL_W'($unsigned(w_rel) >> CELL_SHIFT);
        end
    end

endmodule

// File: rtl/food_placer.sv
// Picks a food cell from the generator's candidate, rejecting cells the snake occupies,
// and falls back to a raster walk once random retries are exhausted.
module food_placer #(
    parameter int unsigned CELL_SHIFT = food_placer_pkg::CELL_SHIFT,
    parameter int unsigned GRID_W     = food_placer_pkg::GRID_W,
    parameter int unsigned GRID_H     = food_placer_pkg::GRID_H,
    parameter int unsigned H_ORIGIN   = food_placer_pkg::H_ORIGIN,
    parameter int unsigned V_ORIGIN   = food_placer_pkg::V_ORIGIN,
    parameter int unsigned MAX_RETRY  = food_placer_pkg::MAX_RETRY
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_cand_x,
    input  logic [9:0] i_cand_y,
    input  logic       i_place_req,
    input  logic [6:0] i_snake_len,
    output logic [5:0] o_seg_addr,
    input  logic [6:0] i_seg_cx,
    input  logic [5:0] i_seg_cy,
    output logic [6:0] o_food_cx,
    output logic [5:0] o_food_cy,
    output logic [9:0] o_food_px,
    output logic [9:0] o_food_py,
    output logic       o_food_valid,
    output logic       o_busy,
    output logic       o_place_done
);

    import food_placer_pkg::*;

    localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);
    localparam logic [6:0] CX_LAST   = 7'(GRID_W - 1);
    localparam logic [5:0] CY_LAST   = 6'(GRID_H - 1);
    localparam logic [9:0] H_ORG     = 10'(H_ORIGIN);
    localparam logic [9:0] V_ORG     = 10'(V_ORIGIN);

    state_t     r_state;
    logic [3:0] r_retry_cnt;
    logic [6:0] r_cand_cx;
    logic [5:0] r_cand_cy;
    logic [6:0] r_len;
    logic [6:0] r_idx;
    logic [5:0] r_seg_addr;
    logic       r_cmp_v;
    logic       r_cmp_last;
    logic [6:0] r_food_cx;
    logic [5:0] r_food_cy;
    logic [9:0] r_food_px;
    logic [9:0] r_food_py;
    logic       r_food_valid;
    logic       r_busy;
    logic       r_place_done;

    logic [6:0] w_qx;
    logic [5:0] w_qy;
    logic       w_hit;

    food_placer_cell_quantizer #(
        .CELL_SHIFT(CELL_SHIFT),
        .ORIGIN    (H_ORIGIN),
        .NUM_CELLS (GRID_W),
        .CELL_W    (7)
    ) u_quant_x (
        .i_coord(i_cand_x),
        .o_cell (w_qx)
    );

    food_placer_cell_quantizer #(
        .CELL_SHIFT(CELL_SHIFT),
        .ORIGIN    (V_ORIGIN),
        .NUM_CELLS (GRID_H),
        .CELL_W    (6)
    ) u_quant_y (
        .i_coord(i_cand_y),
        .o_cell (w_qy)
    );

    assign w_hit = (i_seg_cx == r_cand_cx) && (i_seg_cy == r_cand_cy);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_retry_cnt  <= '0;
            r_cand_cx    <= '0;
            r_cand_cy    <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_seg_addr   <= '0;
            r_cmp_v      <= 1'b0;
            r_cmp_last   <= 1'b0;
            r_food_cx    <= '0;
            r_food_cy    <= '0;
            r_food_px    <= '0;
            r_food_py    <= '0;
            r_food_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_place_done <= 1'b0;
        end else begin
            r_place_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_place_req) begin
                        r_state      <= StSample;
                        r_busy       <= 1'b1;
                        r_food_valid <= 1'b0;
                        r_retry_cnt  <= '0;
                    end
                end
                StSample: begin
                    if (r_retry_cnt < RETRY_LIM) begin
                        r_cand_cx <= w_qx;
                        r_cand_cy <= w_qy;
                    end else if (r_cand_cx == CX_LAST) begin
                        r_cand_cx <= '0;
                        r_cand_cy <= (r_cand_cy == CY_LAST) ? '0 : r_cand_cy + 6'd1;
                    end else begin
                        r_cand_cx <= r_cand_cx + 7'd1;
                    end
                    r_seg_addr <= '0;
                    r_idx      <= '0;
                    r_cmp_v    <= 1'b0;
                    r_cmp_last <= 1'b0;
                    r_len      <= i_snake_len;
                    r_state    <= (i_snake_len == 7'd0) ? StCommit : StScan;
                end
                StScan: begin
                    // Body memory answers one cycle late; the flags travel with the read.
                    r_idx      <= r_idx + 7'd1;
                    r_seg_addr <= 6'(r_idx + 7'd1);
                    r_cmp_v    <= (r_idx < r_len);
                    r_cmp_last <= (r_idx == r_len - 7'd1);
                    if (r_cmp_v && w_hit) begin
                        r_state <= StSample;
                        if (r_retry_cnt != 4'hF) begin
                            r_retry_cnt <= r_retry_cnt + 4'd1;
                        end
                    end else if (r_cmp_v && r_cmp_last) begin
                        r_state <= StCommit;
                    end
                end
                StCommit: begin
                    r_food_cx    <= r_cand_cx;
                    r_food_cy    <= r_cand_cy;
                    r_food_px    <= H_ORG + (10'(r_cand_cx) << CELL_SHIFT);
                    r_food_py    <= V_ORG + (10'(r_cand_cy) << CELL_SHIFT);
                    r_food_valid <= 1'b1;
                    r_place_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_seg_addr   = r_seg_addr;
    assign o_food_cx    = r_food_cx;
    assign o_food_cy    = r_food_cy;
    assign o_food_px    = r_food_px;
    assign o_food_py    = r_food_py;
    assign o_food_valid = r_food_valid;
    assign o_busy       = r_busy;
    assign o_place_done = r_place_done;

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: directed corner cases plus randomized placements checked
// against a cell-level placement model.
module tb_food_placer;

    localparam int HO     = 144;
    localparam int VO     = 35;
    localparam int GW     = 80;
    localparam int GH     = 60;
    localparam int MAXR   = 15;
    localparam int SEQ_N  = 8192;
    localparam int BUDGET = 8000;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] cand_x;
    logic [9:0] cand_y;
    logic       place_req;
    logic [6:0] snake_len;
    logic [5:0] seg_addr;
    logic [6:0] seg_cx;
    logic [5:0] seg_cy;
    logic [6:0] food_cx;
    logic [5:0] food_cy;
    logic [9:0] food_px;
    logic [9:0] food_py;
    logic       food_valid;
    logic       busy;
    logic       place_done;

    int         seq_x [SEQ_N];
    int         seq_y [SEQ_N];
    logic [6:0] mem_x [64];
    logic [5:0] mem_y [64];

    int n_checks = 0;
    int n_errors = 0;
    int obs_lat, obs_ndone, obs_cx, obs_cy, obs_px, obs_py;
    int obs_valid, obs_busy, obs_busy0, obs_valid0, obs_glitch;

    always #5 clk = ~clk;

    // Body memory with one cycle of read latency.
    always @(posedge clk) begin
        seg_cx <= mem_x[seg_addr];
        seg_cy <= mem_y[seg_addr];
    end

    food_placer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cand_x    (cand_x),
        .i_cand_y    (cand_y),
        .i_place_req (place_req),
        .i_snake_len (snake_len),
        .o_seg_addr  (seg_addr),
        .i_seg_cx    (seg_cx),
        .i_seg_cy    (seg_cy),
        .o_food_cx   (food_cx),
        .o_food_cy   (food_cy),
        .o_food_px   (food_px),
        .o_food_py   (food_py),
        .o_food_valid(food_valid),
        .o_busy      (busy),
        .o_place_done(place_done)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int quant(input int v, input int org, input int n);
        int rel;
        rel = v - org;
        if (rel < 0) return 0;
        if (rel >= n * 8) return n - 1;
        return rel / 8;
    endfunction

    // Walks the placement attempts; t is the edge (after the request edge) that samples.
    task automatic model(input int len, output int ecx, output int ecy, output int et);
        int t, r, cx, cy, hit;
        t = 1; r = 0; cx = 0; cy = 0;
        ecx = -1; ecy = -1; et = -1;
        while (t < BUDGET) begin
            if (r < MAXR) begin
                cx = quant(seq_x[t], HO, GW);
                cy = quant(seq_y[t], VO, GH);
            end else begin
                cx = (cx + 1) % GW;
                if (cx == 0) cy = (cy + 1) % GH;
            end
            hit = -1;
            for (int k = 0; k < len; k++) begin
                if (hit < 0 && int'(mem_x[k]) == cx && int'(mem_y[k]) == cy) hit = k;
            end
            if (hit < 0) begin
                ecx = cx;
                ecy = cy;
                et  = (len == 0) ? t + 1 : t + len + 2;
                return;
            end
            t = t + hit + 3;
            if (r < MAXR) r++;
        end
    endtask

    task automatic fill_seq(input int x, input int y);
        for (int t = 0; t < SEQ_N; t++) begin
            seq_x[t] = x;
            seq_y[t] = y;
        end
    endtask

    // Issues one request; seq[t] is the candidate present at edge t after the request edge.
    task automatic run_place(input int dup_t);
        cand_x    = 10'(seq_x[0]);
        cand_y    = 10'(seq_y[0]);
        place_req = 1'b1;
        @(posedge clk); #1;
        place_req  = 1'b0;
        obs_busy0  = int'(busy);
        obs_valid0 = int'(food_valid);
        obs_lat    = -1;
        obs_ndone  = 0;
        obs_glitch = 0;
        obs_cx = -1; obs_cy = -1; obs_px = -1; obs_py = -1;
        obs_valid = -1; obs_busy = -1;
        for (int t = 1; t < BUDGET; t++) begin
            cand_x    = 10'(seq_x[t]);
            cand_y    = 10'(seq_y[t]);
            place_req = (t == dup_t);
            @(posedge clk); #1;
            if (place_done) begin
                obs_ndone++;
                if (obs_lat < 0) begin
                    obs_lat   = t;
                    obs_cx    = int'(food_cx);
                    obs_cy    = int'(food_cy);
                    obs_px    = int'(food_px);
                    obs_py    = int'(food_py);
                    obs_valid = int'(food_valid);
                    obs_busy  = int'(busy);
                end
            end else if (obs_lat < 0 && (food_valid || !busy)) begin
                obs_glitch++;
            end
            if (obs_lat >= 0 && t >= obs_lat + 4) break;
        end
        place_req = 1'b0;
    endtask

    task automatic check_place(input string tag, input int ecx, input int ecy, input int elat);
        check_eq({tag, " latency"}, obs_lat, elat);
        check_eq({tag, " food_cx"}, obs_cx, ecx);
        check_eq({tag, " food_cy"}, obs_cy, ecy);
        check_eq({tag, " food_px"}, obs_px, HO + ecx * 8);
        check_eq({tag, " food_py"}, obs_py, VO + ecy * 8);
        check_eq({tag, " done_count"}, obs_ndone, 1);
        check_eq({tag, " valid_at_commit"}, obs_valid, 1);
        check_eq({tag, " busy_at_commit"}, obs_busy, 0);
        check_eq({tag, " busy_after_req"}, obs_busy0, 1);
        check_eq({tag, " valid_after_req"}, obs_valid0, 0);
        check_eq({tag, " busy_valid_while_working"}, obs_glitch, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ecx, ecy, elat, bx, by;
        rst       = 1'b1;
        place_req = 1'b0;
        cand_x    = '0;
        cand_y    = '0;
        snake_len = '0;
        for (int k = 0; k < 64; k++) begin
            mem_x[k] = '0;
            mem_y[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst busy", int'(busy), 0);
        check_eq("rst food_valid", int'(food_valid), 0);
        check_eq("rst place_done", int'(place_done), 0);
        check_eq("rst seg_addr", int'(seg_addr), 0);
        check_eq("rst food_cx", int'(food_cx), 0);
        check_eq("rst food_cy", int'(food_cy), 0);
        check_eq("rst food_px", int'(food_px), 0);
        check_eq("rst food_py", int'(food_py), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        snake_len = 7'd0;
        fill_seq(HO + 100, VO + 50);
        run_place(-1);
        check_place("basic", 12, 6, 2);

        fill_seq(140, 520);
        run_place(-1);
        check_place("clamp_lo", 0, 59, 2);
        fill_seq(790, 100);
        run_place(-1);
        check_place("clamp_hi", 79, 8, 2);

        // Segment 1 blocks the first sample; the retry sees a free cell.
        snake_len = 7'd3;
        mem_x[0] = 7'd1;  mem_y[0] = 6'd1;
        mem_x[1] = 7'd12; mem_y[1] = 6'd6;
        mem_x[2] = 7'd2;  mem_y[2] = 6'd2;
        fill_seq(HO + 160, VO + 160);
        seq_x[0] = HO + 100; seq_y[0] = VO + 50;
        seq_x[1] = HO + 100; seq_y[1] = VO + 50;
        run_place(-1);
        check_place("collide", 20, 20, 10);

        snake_len = 7'd1;
        mem_x[0] = 7'd79; mem_y[0] = 6'd59;
        fill_seq(HO + 635, VO + 475);
        run_place(-1);
        check_place("fallback", 0, 0, 49);

        snake_len = 7'd3;
        fill_seq(HO + 400, VO + 320);
        run_place(2);
        check_place("dup_req", 50, 40, 6);

        snake_len = 7'd20;
        for (int k = 0; k < 20; k++) begin
            mem_x[k] = 7'(k);
            mem_y[k] = 6'd0;
        end
        cand_x    = 10'(HO + 400);
        cand_y    = 10'(VO + 320);
        place_req = 1'b1;
        @(posedge clk); #1;
        place_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_scan busy", int'(busy), 1);
        check_eq("mid_scan seg_addr", int'(seg_addr), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mid_rst busy", int'(busy), 0);
        check_eq("mid_rst food_valid", int'(food_valid), 0);
        check_eq("mid_rst seg_addr", int'(seg_addr), 0);
        check_eq("mid_rst food_cx", int'(food_cx), 0);
        rst       = 1'b1;
        place_req = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        place_req = 1'b0;
        check_eq("rst_and_req busy", int'(busy), 0);
        @(posedge clk); #1;
        check_eq("rst_and_req busy_later", int'(busy), 0);
        fill_seq(HO + 400, VO + 320);
        run_place(-1);
        check_place("post_rst", 50, 40, 23);

        for (int n = 0; n < 30; n++) begin
            if (n % 4 == 0) begin
                bx = GW - 8;
                by = GH - 8;
            end else begin
                bx = int'($urandom_range(0, GW - 8));
                by = int'($urandom_range(0, GH - 8));
            end
            snake_len = 7'($urandom_range(0, 64));
            for (int k = 0; k < 64; k++) begin
                mem_x[k] = 7'(bx + int'($urandom_range(0, 7)));
                mem_y[k] = 6'(by + int'($urandom_range(0, 7)));
            end
            for (int t = 0; t < SEQ_N; t++) begin
                if ($urandom_range(0, 1) == 1) begin
                    seq_x[t] = HO + bx * 8 + int'($urandom_range(0, 63));
                    seq_y[t] = VO + by * 8 + int'($urandom_range(0, 63));
                end else begin
                    seq_x[t] = int'($urandom_range(HO - 5, HO + GW * 8 + 4));
                    seq_y[t] = int'($urandom_range(VO - 5, VO + GH * 8 + 4));
                end
            end
            model(int'(snake_len), ecx, ecy, elat);
            run_place(-1);
            check_place("rand", ecx, ecy, elat);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/food_placer.md
# food_placer

Downstream consumer of the food generator's raw candidate coordinates. On a placement request it samples the candidate, clamps it to the playfield, and quantizes it to a grid cell. It then scans the snake body memory and accepts the cell only if no segment occupies it; otherwise it retries. It publishes the committed food cell and its pixel origin to the renderer and collision logic.

## Interface
Parameters:
- CELL_SHIFT, 3: cell size is 2^CELL_SHIFT pixels (8x8).
- GRID_W, 80: playfield width in cells.
- GRID_H, 60: playfield height in cells.
- H_ORIGIN, 144: first active pixel column in VGA timing coordinates (H_SYNC_CYC+H_SYNC_BACK).
- V_ORIGIN, 35: first active line in VGA timing coordinates (V_SYNC_CYC+V_SYNC_BACK).
- MAX_RETRY, 15: rejected random samples before switching to linear fallback.

Ports:
- clk  in  1  system clock; one clock, no other clocks in this block.
- rst  in  1  synchronous, active-high reset.
- cand_x  in  10  raw candidate X from food generator, in VGA timing coordinates.
- cand_y  in  10  raw candidate Y, in VGA timing coordinates.
- place_req  in  1  one-cycle request for a new food position (game start or food eaten).
- snake_len  in  7  number of valid body segments, 0..64.
- seg_addr  out  6  body memory read address.
- seg_cx  in  7  segment cell X; valid one cycle after seg_addr.
- seg_cy  in  6  segment cell Y; valid one cycle after seg_addr.
- food_cx  out  7  committed food cell X.
- food_cy  out  6  committed food cell Y.
- food_px  out  10  H_ORIGIN + (food_cx << CELL_SHIFT).
- food_py  out  10  V_ORIGIN + (food_cy << CELL_SHIFT).
- food_valid  out  1  committed position is valid and drawable.
- busy  out  1  high in every state except IDLE.
- place_done  out  1  one-cycle pulse on commit.

## Operation
- FSM states: IDLE, SAMPLE, SCAN, COMMIT.
- **IDLE**
  - place_req=1 → SAMPLE; food_valid<=0; retry_cnt<=0.
  - place_req is ignored in all other states.
- **SAMPLE**
  - retry_cnt < MAX_RETRY: latch the clamped, quantized cand_x/cand_y into cand_cx/cand_cy.
  - Otherwise: advance the previous candidate in raster order: cx+1; at GRID_W-1 wrap cx to 0 and advance cy+1; at GRID_H-1 wrap cy to 0.
  - seg_addr<=0; idx<=0.
  - snake_len=0 → COMMIT; else → SCAN.
- **Clamp and quantize**
  - rel = cand - ORIGIN, computed at 11 bits signed.
  - rel<0 → cell 0.
  - rel ≥ GRID_W<<CELL_SHIFT (or GRID_H<<CELL_SHIFT) → cell GRID_W-1 (or GRID_H-1).
  - Else cell = rel >> CELL_SHIFT.
  - This handles the generator's ±5-pixel margin around the active area.
- **SCAN**
  - Present seg_addr=idx each cycle, then idx+1.
  - A compare-valid flag delayed one cycle qualifies seg_cx/seg_cy.
  - Hit (seg == cand): abort scan → SAMPLE; retry_cnt saturating increment (4 bits).
  - Last compare (address snake_len-1) without a hit → COMMIT.
- **COMMIT**
  - Load food_cx/cy/px/py; food_valid<=1; place_done<=1 for one cycle → IDLE.
- **Reset or mid-operation reset:** state IDLE; all outputs 0 (food_valid=0, busy=0, place_done=0, seg_addr=0, food_* =0); retry_cnt=0.
- **Simultaneous rst and place_req:** reset wins.
- **Termination:** the fallback walk guarantees termination whenever snake_len < GRID_W*GRID_H. A full grid is impossible because MAX_LEN=64.

## Timing
- Outputs are registered; there are no combinational paths from inputs to outputs.
- No-collision latency, counted from the edge that samples place_req to the edge that raises food_valid and place_done:
  - snake_len+3 edges for snake_len ≥ 1.
  - 2 edges for snake_len=0.
- Collision at segment k: the FSM re-enters SAMPLE k+3 edges after entering SCAN.
- busy rises on the edge after place_req is sampled and falls with the COMMIT→IDLE edge.
- food_valid stays 0 from request acceptance until commit.
- snake_len and cand_* are sampled only in SAMPLE. Body memory contents must be stable while busy=1.

## Structure
- Shared package/include: CELL_SHIFT, GRID_W, GRID_H, FSM state encoding, and the ORIGIN constants derived from VGA_Param.h (H_SYNC_CYC+H_SYNC_BACK, V_SYNC_CYC+V_SYNC_BACK).
- One natural sub-module: cell_quantizer, the combinational clamp plus shift for one axis, instantiated once for X and once for Y.
- Scan counter, compare pipeline, and FSM stay in food_placer.

## Test plan
- **Basic placement:** snake_len=0, cand=(144+100, 35+50), place_req pulse → place_done 2 edges later; food_cx=12, food_cy=6, food_px=240, food_py=83.
- **Clamp:** cand_x=140, cand_y=520 → food_cx=0, food_cy=59. cand_x=790 → food_cx=79.
- **Collision retry:** snake_len=3 with segment 1 at (12,6). Hold cand at cell (12,6) for the first sample, then move it to (20,20) → commit at (20,20), latency greater than 6 edges, exactly one place_done.
- **Fallback:** cand fixed at cell (79,59), occupied by segment 0 → after 15 rejects, commits at (0,0) via raster wrap.
- **Busy and reset:** place_req pulse while busy=1 is ignored (single place_done). Asserting rst mid-SCAN → next cycle busy=0, food_valid=0, seg_addr=0. A new request then completes normally.
